// File: rtl/mask_ser_pkg.sv
// Shared constants, state encoding and clear-mask helper for the mask serializer.
package mask_ser_pkg;

  localparam int WIDTH = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // One-hot mask of the bit being emitted this cycle; all-zero when nothing is emitted.
  function automatic logic [WIDTH-1:0] onehot_clear(input logic [IDX_W-1:0] idx, input logic en);
    return en ? (WIDTH'(1) << idx) : '0;
  endfunction

endpackage

// File: rtl/mask_serializer_ffs16.sv
// Combinational find-first-set over a 16-bit vector: lowest set index, any-set and exactly-one-set flags.
module ffs16
  import mask_ser_pkg::*;
(
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found,
  output logic             single
);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign found  = |vec;
  assign single = found && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/mask_serializer.sv
// Serializes a request mask into ascending set-bit indices, one per output handshake.
// Optional build macro MASK_SER_MERGE_EN lets new masks OR-merge into a scan in progress.
module mask_serializer
  import mask_ser_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  state_e           state;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] next_pending;
  logic             found;
  logic             single;
  logic             accept;
  logic             emit;

  ffs16 u_ffs (
    .vec   (pending),
    .idx   (out_idx),
    .found (found),
    .single(single)
  );

  // All outputs derive from registered state/pending only; in_* never reach out_*.
  assign out_valid = (state == SCAN);
  assign out_last  = out_valid & single;
  assign busy      = found;

`ifdef MASK_SER_MERGE_EN
  assign in_ready = 1'b1;
`else
  assign in_ready = (state == IDLE);
`endif

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // A bit emitted and re-requested in the same cycle survives the clear via the OR.
  always_comb begin
    next_pending = pending & ~onehot_clear(out_idx, emit);
    if (accept) next_pending = next_pending | in_mask;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      pending <= next_pending;
      state   <= (next_pending != '0) ? SCAN : IDLE;
    end
  end

endmodule

// File: tb/tb_mask_serializer.sv
// Self-checking bench for mask_serializer: directed cases plus random masks against a queue model.
module tb_mask_serializer;
  import mask_ser_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_mask = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             busy;

  int errors = 0;
  int checks = 0;

  mask_serializer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mask  (in_mask),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer a mask at the next negedge and hold it through one rising edge.
  task automatic start(input logic [WIDTH-1:0] mask);
    @(negedge clk);
    in_valid = 1'b1;
    in_mask  = mask;
    check("start_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Model: the expected index stream is simply every set bit, ascending.
  // mode 0: out_ready always high; 1: random; 2: follow pat bit per cycle.
  task automatic drain(input string tag, input logic [WIDTH-1:0] mask, input int mode,
                       input logic [31:0] pat);
    int q[$];
    int cyc;
    bit done;
    for (int i = 0; i < WIDTH; i++) if (mask[i]) q.push_back(i);
    cyc  = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (q.size() == 0) begin
        check({tag, "_end_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_end_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_end_busy"}, 32'(busy), 32'd0);
        out_ready = 1'b0;
        done = 1'b1;
      end else if (cyc >= 100) begin
        check({tag, "_timeout"}, 32'(q.size()), 32'd0);
        done = 1'b1;
      end else begin
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_idx"}, 32'(out_idx), 32'(q[0]));
        check({tag, "_last"}, 32'(out_last), 32'(q.size() == 1));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        case (mode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = pat[cyc % 32];
        endcase
        if (out_ready) void'(q.pop_front());
        cyc++;
      end
    end
  endtask

  initial begin
    logic [WIDTH-1:0] m;

    // Outputs while held in reset.
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-scan: emit 4 and 5 of 0x00F0, then reset asynchronously.
    start(16'h00F0);
    @(negedge clk);
    check("rms_idx0", 32'(out_idx), 32'd4);
    out_ready = 1'b1;
    @(negedge clk);
    check("rms_idx1", 32'(out_idx), 32'd5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rms_out_valid", 32'(out_valid), 32'd0);
    check("rms_busy", 32'(busy), 32'd0);
    check("rms_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rms_no_stale", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

    // Basic stream, back-pressure, boundary masks.
    start(16'h1081);
    drain("basic", 16'h1081, 0, 32'h0);
    start(16'h0006);
    drain("bp", 16'h0006, 2, 32'b10100);
    start(16'h8000);
    drain("b8000", 16'h8000, 0, 32'h0);
    start(16'hFFFF);
    drain("bffff", 16'hFFFF, 0, 32'h0);
    start(16'h0000);
    drain("bzero", 16'h0000, 0, 32'h0);

    // Back-to-back: 0x0003 is offered during the 0x0100 scan and must wait.
    start(16'h0100);
    in_valid = 1'b1;
    in_mask  = 16'h0003;
    drain("b2b_a", 16'h0100, 0, 32'h0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain("b2b_b", 16'h0003, 0, 32'h0);

    // Random masks with random back-pressure.
    for (int n = 0; n < 20; n++) begin
      m = WIDTH'($urandom);
      if (n % 5 == 0) m = m & WIDTH'($urandom);
      start(m);
      drain("rand", m, 1, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
